// File: rtl/cpu_sdram_wb_master.sv
// Bridge from the OpenMIPS memory stage to the SDRAM controller Wishbone slave.
// Each CPU access becomes one classic Wishbone cycle. The pipeline is stalled
// until ack. A flush never aborts an open bus cycle, and a watchdog ends
// cycles that the slave never acknowledges.
module cpu_sdram_wb_master #(
  parameter int AW    = 26,
  parameter int DW    = 32,
  parameter int TMO_W = 10
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            sdr_init_done_i,
  input  logic            cpu_ce_i,
  input  logic            cpu_we_i,
  input  logic [31:0]     cpu_addr_i,
  input  logic [DW-1:0]   cpu_data_i,
  input  logic [DW/8-1:0] cpu_sel_i,
  input  logic            cpu_stall_i,
  input  logic            flush_i,
  output logic [DW-1:0]   cpu_data_o,
  output logic            stall_req_o,
  output logic            err_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_stb_o,
  output logic            wb_cyc_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i
);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_FLUSH, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TMO_W-1:0] wdog;
  logic [TMO_W-1:0] wdog_inc;
  logic             open_cyc;
  logic             start;
  logic             ack;
  logic             tmo;
  logic             unused_addr;

  // The SDRAM window is narrower than the CPU address space.
  assign unused_addr = ^cpu_addr_i[31:AW];

  assign wb_cti_o = 3'b000;
  assign open_cyc = (state == BUSY) || (state == WAIT_FLUSH);
  assign start    = (state == IDLE) && cpu_ce_i && !flush_i && sdr_init_done_i;
  // Ack is only honoured while a cycle is open, so stray acks are ignored.
  assign ack      = open_cyc && wb_ack_i;
  assign wdog_inc = wdog + 1'b1;
  // The timeout fires on the edge that brings the watchdog to all-ones.
  // Ack on that same edge wins.
  assign tmo      = open_cyc && !wb_ack_i && (wdog_inc == {TMO_W{1'b1}});

  // Keep the CPU stalled while a request is pending or in flight; a flush always releases it.
  assign stall_req_o = cpu_ce_i && !flush_i && ((state == IDLE) || (state == BUSY));

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode for the access sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = BUSY;
      end
      BUSY: begin
        if (ack) begin
          if (flush_i)          state_nxt = IDLE;
          else if (cpu_stall_i) state_nxt = DONE;
          else                  state_nxt = IDLE;
        end else if (tmo) begin
          state_nxt = DONE;
        end else if (flush_i) begin
          state_nxt = WAIT_FLUSH;
        end
      end
      WAIT_FLUSH: begin
        if (ack || tmo) state_nxt = IDLE;
      end
      DONE: begin
        if (!cpu_stall_i || flush_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs, load data capture, watchdog and error pulse.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_addr_o  <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
      wb_we_o    <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_cyc_o   <= 1'b0;
      cpu_data_o <= '0;
      err_o      <= 1'b0;
      wdog       <= '0;
    end else begin
      err_o <= tmo;
      if (start) begin
        wb_addr_o <= cpu_addr_i[AW-1:0];
        wb_dat_o  <= cpu_data_i;
        wb_sel_o  <= cpu_sel_i;
        wb_we_o   <= cpu_we_i;
        wb_stb_o  <= 1'b1;
        wb_cyc_o  <= 1'b1;
        wdog      <= '0;
      end else if (open_cyc) begin
        wdog <= wdog_inc;
        if (ack || tmo) begin
          wb_stb_o <= 1'b0;
          wb_cyc_o <= 1'b0;
          wb_we_o  <= 1'b0;
          wb_sel_o <= '0;
        end
        // Only a load that is still wanted by the pipeline delivers data.
        if ((state == BUSY) && ack && !wb_we_o && !flush_i) cpu_data_o <= wb_dat_i;
        if (tmo) cpu_data_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sdram_wb_master.sv
// Directed testbench for cpu_sdram_wb_master (watchdog shortened to TMO_W=4).
module tb_cpu_sdram_wb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_done = 1'b0;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] cdata = '0;
  logic [3:0]  sel = '0;
  logic        cstall = 1'b0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] rdat = '0;
  logic [31:0] data_o;
  logic        stall_req;
  logic        err;
  logic [25:0] wb_addr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_cyc;
  logic [2:0]  wb_cti;

  int checks = 0;
  int errors = 0;

  cpu_sdram_wb_master #(.AW(26), .DW(32), .TMO_W(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .sdr_init_done_i(init_done),
    .cpu_ce_i(ce), .cpu_we_i(we), .cpu_addr_i(addr), .cpu_data_i(cdata),
    .cpu_sel_i(sel), .cpu_stall_i(cstall), .flush_i(flush),
    .cpu_data_o(data_o), .stall_req_o(stall_req), .err_o(err),
    .wb_addr_o(wb_addr), .wb_dat_o(wb_dat), .wb_sel_o(wb_sel), .wb_we_o(wb_we),
    .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc), .wb_cti_o(wb_cti),
    .wb_ack_i(ack), .wb_dat_i(rdat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(); step();
    #1;
    checks++; if ({wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_dat} !== '0) begin errors++; $display("FAIL reset_wb: got cyc=%b stb=%b we=%b sel=%h addr=%h dat=%h required all 0", wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_dat); end
    checks++; if (data_o !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL reset_data: got data=%h err=%b required 0/0", data_o, err); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %b required 0", stall_req); end
    ce = 1'b1; #1;
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL reset_stall_ce: got %b required 1", stall_req); end
    ce = 1'b0;
    step();
    rst = 1'b0; init_done = 1'b1;
    step();
  endtask

  task automatic test_load();
    ce = 1'b1; we = 1'b0; addr = 32'h0000_0104; sel = 4'hF; cdata = 32'h0;
    #1;
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL load_stall_req: got %b required 1", stall_req); end
    step();
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) begin ack = 1'b1; rdat = 32'hDEAD_BEEF; end
      #1;
      checks++; if (!(wb_cyc === 1'b1 && wb_stb === 1'b1 && stall_req === 1'b1 && wb_addr === 26'h104 && wb_we === 1'b0)) begin errors++; $display("FAIL load_busy k=%0d: got cyc=%b stb=%b stall=%b addr=%h we=%b required 1/1/1/104/0", k, wb_cyc, wb_stb, stall_req, wb_addr, wb_we); end
      step();
    end
    ack = 1'b0; ce = 1'b0; #1;
    checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin errors++; $display("FAIL load_drop: got cyc=%b stb=%b required 0/0", wb_cyc, wb_stb); end
    checks++; if (data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data: got %h required deadbeef", data_o); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL load_release: got %b required 0", stall_req); end
    step();
  endtask

  task automatic test_store();
    ce = 1'b1; we = 1'b1; addr = 32'h0000_0200; sel = 4'b0011; cdata = 32'h1234_5678;
    step();
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin ack = 1'b1; rdat = 32'hCAFE_F00D; end
      #1;
      checks++; if (!(wb_cyc === 1'b1 && wb_we === 1'b1 && wb_sel === 4'b0011 && wb_dat === 32'h1234_5678 && wb_cti === 3'b000 && wb_addr === 26'h200)) begin errors++; $display("FAIL store_bus k=%0d: got cyc=%b we=%b sel=%b dat=%h cti=%b addr=%h required 1/1/0011/12345678/000/200", k, wb_cyc, wb_we, wb_sel, wb_dat, wb_cti, wb_addr); end
      step();
    end
    ack = 1'b0; ce = 1'b0; we = 1'b0; #1;
    checks++; if (data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_data_kept: got %h required deadbeef", data_o); end
    checks++; if (wb_cyc !== 1'b0 || wb_we !== 1'b0 || wb_sel !== 4'b0000) begin errors++; $display("FAIL store_drop: got cyc=%b we=%b sel=%b required 0/0/0000", wb_cyc, wb_we, wb_sel); end
    step();
  endtask

  task automatic test_init_hold();
    init_done = 1'b0; ce = 1'b1; we = 1'b0; addr = 32'h0000_0300; sel = 4'hF;
    for (int k = 0; k < 20; k++) begin
      #1;
      checks++; if (wb_cyc !== 1'b0 || stall_req !== 1'b1) begin errors++; $display("FAIL init_hold k=%0d: got cyc=%b stall=%b required 0/1", k, wb_cyc, stall_req); end
      step();
    end
    init_done = 1'b1;
    step();
    checks++; if (wb_cyc !== 1'b1 || wb_addr !== 26'h300) begin errors++; $display("FAIL init_start: got cyc=%b addr=%h required 1/300", wb_cyc, wb_addr); end
    ack = 1'b1; rdat = 32'h1111_2222;
    step();
    ack = 1'b0; ce = 1'b0; #1;
    checks++; if (data_o !== 32'h1111_2222) begin errors++; $display("FAIL init_data: got %h required 11112222", data_o); end
    step();
  endtask

  task automatic test_flush();
    ce = 1'b1; we = 1'b0; addr = 32'h0000_0400; sel = 4'hF;
    step();
    step();
    flush = 1'b1; #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b required 0", stall_req); end
    step();
    flush = 1'b0; addr = 32'h0000_0500;
    for (int k = 3; k <= 6; k++) begin
      if (k == 6) begin ack = 1'b1; rdat = 32'h5555_5555; end
      #1;
      checks++; if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || stall_req !== 1'b0 || wb_addr !== 26'h400) begin errors++; $display("FAIL flush_wait k=%0d: got cyc=%b stb=%b stall=%b addr=%h required 1/1/0/400", k, wb_cyc, wb_stb, stall_req, wb_addr); end
      step();
    end
    ack = 1'b0; #1;
    checks++; if (wb_cyc !== 1'b0 || data_o !== 32'h1111_2222) begin errors++; $display("FAIL flush_discard: got cyc=%b data=%h required 0/11112222", wb_cyc, data_o); end
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL flush_idle_stall: got %b required 1", stall_req); end
    step();
    checks++; if (wb_cyc !== 1'b1 || wb_addr !== 26'h500) begin errors++; $display("FAIL flush_next: got cyc=%b addr=%h required 1/500", wb_cyc, wb_addr); end
    ack = 1'b1; rdat = 32'h6666_6666;
    step();
    ack = 1'b0; ce = 1'b0; #1;
    checks++; if (data_o !== 32'h6666_6666) begin errors++; $display("FAIL flush_next_data: got %h required 66666666", data_o); end
    step();
  endtask

  task automatic test_timeout();
    ce = 1'b1; we = 1'b0; addr = 32'h0000_0600;
    step();
    for (int k = 1; k <= 15; k++) begin
      #1;
      checks++; if (wb_cyc !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL tmo_busy k=%0d: got cyc=%b err=%b required 1/0", k, wb_cyc, err); end
      step();
    end
    #1;
    checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin errors++; $display("FAIL tmo_drop: got cyc=%b stb=%b required 0/0", wb_cyc, wb_stb); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b required 1", err); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL tmo_data: got %h required 0", data_o); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL tmo_done_stall: got %b required 0", stall_req); end
    ce = 1'b0;
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got %b required 0", err); end
    step();
  endtask

  task automatic test_ack_at_limit();
    ce = 1'b1; we = 1'b0; addr = 32'h0000_0700;
    step();
    for (int k = 1; k <= 15; k++) begin
      if (k == 15) begin ack = 1'b1; rdat = 32'h0F0F_0F0F; end
      step();
    end
    ack = 1'b0; ce = 1'b0; #1;
    checks++; if (err !== 1'b0 || wb_cyc !== 1'b0) begin errors++; $display("FAIL limit_ack: got err=%b cyc=%b required 0/0", err, wb_cyc); end
    checks++; if (data_o !== 32'h0F0F_0F0F) begin errors++; $display("FAIL limit_data: got %h required 0f0f0f0f", data_o); end
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL limit_err_late: got %b required 0", err); end
  endtask

  task automatic test_stall_done();
    ce = 1'b1; we = 1'b0; addr = 32'h0000_0800;
    step();
    ack = 1'b1; cstall = 1'b1; rdat = 32'hA5A5_A5A5;
    step();
    ack = 1'b0; #1;
    checks++; if (stall_req !== 1'b0 || wb_cyc !== 1'b0 || data_o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL done_enter: got stall=%b cyc=%b data=%h required 0/0/a5a5a5a5", stall_req, wb_cyc, data_o); end
    step();
    checks++; if (stall_req !== 1'b0 || wb_cyc !== 1'b0 || data_o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL done_hold: got stall=%b cyc=%b data=%h required 0/0/a5a5a5a5", stall_req, wb_cyc, data_o); end
    cstall = 1'b0;
    step();
    checks++; if (stall_req !== 1'b1 || wb_cyc !== 1'b0) begin errors++; $display("FAIL done_exit: got stall=%b cyc=%b required 1/0", stall_req, wb_cyc); end
    ce = 1'b0;
    step();
  endtask

  task automatic test_ack_ignored();
    ack = 1'b1; rdat = 32'hBAD0_BAD0;
    step(); step();
    ack = 1'b0; #1;
    checks++; if (data_o !== 32'hA5A5_A5A5 || wb_cyc !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL stray_ack: got data=%h cyc=%b err=%b required a5a5a5a5/0/0", data_o, wb_cyc, err); end
    step();
  endtask

  task automatic test_reset_mid();
    ce = 1'b1; we = 1'b1; addr = 32'h0000_0900; cdata = 32'h0000_0077; sel = 4'hF;
    step();
    #1;
    checks++; if (wb_cyc !== 1'b1) begin errors++; $display("FAIL rstmid_open: got cyc=%b required 1", wb_cyc); end
    rst = 1'b1; ce = 1'b0; #1;
    checks++; if ({wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_dat} !== '0 || data_o !== 32'h0 || err !== 1'b0 || stall_req !== 1'b0) begin errors++; $display("FAIL rstmid_async: got cyc=%b stb=%b we=%b sel=%h addr=%h dat=%h data=%h err=%b stall=%b required all 0", wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_dat, data_o, err, stall_req); end
    step();
    rst = 1'b0;
    step(); step();
    checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL rstmid_after: got cyc=%b required 0", wb_cyc); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_init_hold();
    test_flush();
    test_timeout();
    test_ack_at_limit();
    test_stall_done();
    test_ack_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
